// File: rtl/sd_block_server.sv
// Responder side of the sd_rd/sd_wr/sd_ack block handshake: serves 512-byte
// blocks of a linear disk image held in a byte-wide backing memory.
module sd_block_server #(
  parameter int MEM_AW  = 24,
  parameter int DIN_LAT = 1,
  parameter int ACK_GAP = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              img_mounted,
  input  logic [63:0]       img_size,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic              sd_buff_wr,
  output logic [7:0]        sd_buff_dout,
  input  logic [7:0]        sd_buff_din,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic              err_oor
);

  localparam logic [7:0] LAT_LAST = 8'((DIN_LAT > 0) ? DIN_LAT - 1 : 0);
  localparam logic [7:0] GAP_LAST = 8'((ACK_GAP > 0) ? ACK_GAP - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_PUSH,
    WR_ADDR,
    WR_CAP,
    WR_REQ,
    DONE,
    GAP
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [31:0] blk_cnt_reg;
  logic [31:0] lba_reg;
  logic [8:0]  idx_reg;
  logic        oor_reg;
  logic [7:0]  lat_cnt_reg;
  logic [7:0]  gap_cnt_reg;
  logic        sd_ack_reg;
  logic [7:0]  dout_reg;
  logic [7:0]  wdata_reg;

  logic        start_req;
  logic        last_byte;
  logic        byte_done;

  // Only bits [40:9] of the image size matter: whole blocks, 32-bit count.
  logic        unused_img_bits;
  assign unused_img_bits = ^{img_size[63:41], img_size[8:0]};

  assign start_req = sd_wr | sd_rd;
  assign last_byte = (idx_reg == 9'd511);
  assign byte_done = (state_reg == RD_PUSH)
                   | ((state_reg == WR_CAP) & oor_reg)
                   | ((state_reg == WR_REQ) & mem_ready);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (sd_wr) begin
          state_next = WR_ADDR;
        end else if (sd_rd) begin
          state_next = RD_REQ;
        end
      end
      RD_REQ: begin
        if (oor_reg || mem_ready) begin
          state_next = RD_PUSH;
        end
      end
      RD_PUSH: begin
        state_next = last_byte ? DONE : RD_REQ;
      end
      WR_ADDR: begin
        if (lat_cnt_reg == LAT_LAST) begin
          state_next = WR_CAP;
        end
      end
      WR_CAP: begin
        // Out-of-range writes never touch memory; the byte is simply dropped.
        if (oor_reg) begin
          state_next = last_byte ? DONE : WR_ADDR;
        end else begin
          state_next = WR_REQ;
        end
      end
      WR_REQ: begin
        if (mem_ready) begin
          state_next = last_byte ? DONE : WR_ADDR;
        end
      end
      DONE: begin
        state_next = (ACK_GAP > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_cnt_reg <= '0;
      lba_reg     <= '0;
      idx_reg     <= '0;
      oor_reg     <= 1'b0;
      lat_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      sd_ack_reg  <= 1'b0;
      dout_reg    <= '0;
      wdata_reg   <= '0;
    end else begin
      if (img_mounted) begin
        blk_cnt_reg <= img_size[40:9];
      end

      // The block number is frozen here so a later lba bump cannot disturb it.
      if (state_reg == IDLE && start_req) begin
        lba_reg    <= sd_lba;
        oor_reg    <= (sd_lba >= blk_cnt_reg);
        idx_reg    <= '0;
        sd_ack_reg <= 1'b1;
      end else if (state_next == DONE) begin
        sd_ack_reg <= 1'b0;
      end

      if (byte_done) begin
        idx_reg <= last_byte ? 9'd0 : idx_reg + 9'd1;
      end

      if (state_reg == RD_REQ) begin
        if (oor_reg) begin
          dout_reg <= 8'h00;
        end else if (mem_ready) begin
          dout_reg <= mem_rdata;
        end
      end

      if (state_reg == WR_CAP) begin
        wdata_reg <= sd_buff_din;
      end

      lat_cnt_reg <= (state_reg == WR_ADDR) ? lat_cnt_reg + 8'd1 : 8'd0;
      gap_cnt_reg <= (state_reg == GAP) ? gap_cnt_reg + 8'd1 : 8'd0;
    end
  end

  // Output logic
  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    sd_buff_wr = 1'b0;
    err_oor    = 1'b0;
    case (state_reg)
      RD_REQ:  mem_rd     = ~oor_reg;
      RD_PUSH: sd_buff_wr = 1'b1;
      WR_REQ:  mem_wr     = 1'b1;
      DONE:    err_oor    = oor_reg;
      default: ;
    endcase
  end

  assign sd_ack       = sd_ack_reg;
  assign sd_buff_addr = idx_reg;
  assign sd_buff_dout = dout_reg;
  assign mem_wdata    = wdata_reg;
  assign mem_addr     = {lba_reg[MEM_AW-10:0], idx_reg};

endmodule
